// File: rtl/urv_trap_unit.sv
// Machine-mode trap controller for the uRV core: owns mstatus/mie/mip/mepc/mcause and supplies trap redirect.
// Optional URV_TRAP_VECTORED_EN: interrupts vector to VECTOR_BASE + 4*code instead of VECTOR_BASE.
module urv_trap_unit #(
  parameter int          NUM_IRQ       = 8,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000,
  parameter logic [31:0] VECTOR_BASE   = 32'h00000008
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               x_stall_i,
  input  logic               x_kill_i,
  input  logic               d_is_csr_i,
  input  logic               d_is_eret_i,
  input  logic [11:0]        d_csr_sel_i,
  input  logic [31:0]        x_csr_write_value_i,
  input  logic               exc_invalid_insn_i,
  input  logic               exc_breakpoint_i,
  input  logic               exc_unaligned_load_i,
  input  logic               exc_unaligned_store_i,
  input  logic               tick_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [31:0]        x_exception_pc_i,
  output logic               x_exception_o,
  output logic [31:0]        x_exception_pc_o,
  output logic [31:0]        x_exception_vector_o,
  output logic               x_double_fault_o,
  output logic [31:0]        csr_mstatus_o,
  output logic [31:0]        csr_mie_o,
  output logic [31:0]        csr_mip_o,
  output logic [31:0]        csr_mepc_o,
  output logic [31:0]        csr_mcause_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0]        LINE_MASK  = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16);
  localparam logic [31:0]        MIE_MASK   = LINE_MASK | 32'h0000_0080;
  localparam logic [NUM_IRQ-1:0] EDGE_LINES = IRQ_EDGE_MASK[NUM_IRQ-1:0];

  typedef enum logic {
    S_IDLE,
    S_TRAP
  } state_t;

  state_t state, state_next;

  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mie_q;
  logic               tick_pending;
  logic [NUM_IRQ-1:0] line_pending, irq_prev;
  logic [NUM_IRQ-1:0] line_keep, line_next;
  logic [31:0]        mepc_q, mcause_q;
  logic               double_fault_q;

  logic        advance, sync_exc, irq_take, exc_take;
  logic        csr_we, mip_we;
  logic [31:0] mip_vec, enabled;
  logic        line_hit, cause_irq;
  logic [4:0]  line_idx, cause_code;

  assign advance  = !x_stall_i && !x_kill_i;
  assign sync_exc = exc_invalid_insn_i | exc_breakpoint_i | exc_unaligned_load_i | exc_unaligned_store_i;
  assign mip_vec  = (32'(line_pending) << 16) | {24'd0, tick_pending, 7'd0};
  assign enabled  = mip_vec & mie_q;
  assign irq_take = mstatus_mie && (|enabled);

  // A trap entry swallows any CSR write issued by the same instruction.
  assign csr_we = advance && d_is_csr_i && !exc_take;
  assign mip_we = csr_we && (d_csr_sel_i == CSR_MIP);

  // Lowest-numbered enabled external line wins among the lines.
  always_comb begin
    line_hit = 1'b0;
    line_idx = 5'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (enabled[16 + k]) begin
        line_hit = 1'b1;
        line_idx = 5'(16 + k);
      end
    end
  end

  always_comb begin
    cause_irq  = 1'b0;
    cause_code = 5'd0;
    if (exc_invalid_insn_i) begin
      cause_code = 5'd2;
    end else if (exc_breakpoint_i) begin
      cause_code = 5'd3;
    end else if (exc_unaligned_load_i) begin
      cause_code = 5'd4;
    end else if (exc_unaligned_store_i) begin
      cause_code = 5'd6;
    end else if (line_hit) begin
      cause_irq  = 1'b1;
      cause_code = line_idx;
    end else if (enabled[7]) begin
      cause_irq  = 1'b1;
      cause_code = 5'd7;
    end
  end

  always_comb begin
    state_next = state;
    exc_take   = 1'b0;
    if (state == S_IDLE) begin
      exc_take = !x_kill_i && (sync_exc || irq_take);
    end
    if (advance) begin
      if (exc_take) begin
        state_next = S_TRAP;
      end else if (d_is_eret_i) begin
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Edge lines latch rises and only clear on a written 0; level lines mirror the input.
  always_comb begin
    line_keep = mip_we ? x_csr_write_value_i[16 +: NUM_IRQ] : {NUM_IRQ{1'b1}};
    line_next = (EDGE_LINES & ((irq_i & ~irq_prev) | (line_pending & line_keep)))
              | (~EDGE_LINES & irq_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_pending <= 1'b0;
      line_pending <= '0;
      irq_prev     <= '0;
    end else begin
      tick_pending <= tick_i | (tick_pending & (mip_we ? x_csr_write_value_i[7] : 1'b1));
      line_pending <= line_next;
      irq_prev     <= irq_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else if (advance) begin
      if (exc_take) begin
        mepc_q       <= x_exception_pc_i;
        mcause_q     <= {cause_irq, 26'd0, cause_code};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (d_is_eret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (d_csr_sel_i)
          CSR_MSTATUS: begin
            mstatus_mie  <= x_csr_write_value_i[3];
            mstatus_mpie <= x_csr_write_value_i[7];
          end
          CSR_MIE:    mie_q    <= x_csr_write_value_i & MIE_MASK;
          CSR_MEPC:   mepc_q   <= x_csr_write_value_i;
          CSR_MCAUSE: mcause_q <= {x_csr_write_value_i[31], 26'd0, x_csr_write_value_i[4:0]};
          default:    ;
        endcase
      end
    end
  end

  // A synchronous exception raised inside a handler cannot be serviced, so flag it permanently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      double_fault_q <= 1'b0;
    end else if (state == S_TRAP && advance && sync_exc) begin
      double_fault_q <= 1'b1;
    end
  end

  assign x_exception_o    = exc_take;
  assign x_exception_pc_o = mepc_q;
  assign x_double_fault_o = double_fault_q;
  assign csr_mstatus_o    = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
  assign csr_mie_o        = mie_q;
  assign csr_mip_o        = mip_vec;
  assign csr_mepc_o       = mepc_q;
  assign csr_mcause_o     = mcause_q;

`ifdef URV_TRAP_VECTORED_EN
  assign x_exception_vector_o = (exc_take && cause_irq)
                              ? VECTOR_BASE + {25'd0, cause_code, 2'b00}
                              : VECTOR_BASE;
`else
  assign x_exception_vector_o = VECTOR_BASE;
`endif

endmodule

// File: tb/tb_urv_trap_unit.sv
// Directed bench for urv_trap_unit: lines 0-3 edge-triggered, lines 4-7 level-sensitive.
module tb_urv_trap_unit;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MIE     = 12'h304;
  localparam logic [11:0] MIP     = 12'h344;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, kill, is_csr, is_eret;
  logic [11:0] csr_sel;
  logic [31:0] wdata;
  logic        exc_ill, exc_bp, exc_ld, exc_st, tick;
  logic [7:0]  irq;
  logic [31:0] pc;
  logic        exc_o, dfault;
  logic [31:0] epc_o, vec_o, mstatus, mie, mip, mepc, mcause;

  int compared   = 0;
  int mismatched = 0;

  urv_trap_unit #(
    .NUM_IRQ      (8),
    .IRQ_EDGE_MASK(16'h000F),
    .VECTOR_BASE  (32'h00000008)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .x_stall_i            (stall),
    .x_kill_i             (kill),
    .d_is_csr_i           (is_csr),
    .d_is_eret_i          (is_eret),
    .d_csr_sel_i          (csr_sel),
    .x_csr_write_value_i  (wdata),
    .exc_invalid_insn_i   (exc_ill),
    .exc_breakpoint_i     (exc_bp),
    .exc_unaligned_load_i (exc_ld),
    .exc_unaligned_store_i(exc_st),
    .tick_i               (tick),
    .irq_i                (irq),
    .x_exception_pc_i     (pc),
    .x_exception_o        (exc_o),
    .x_exception_pc_o     (epc_o),
    .x_exception_vector_o (vec_o),
    .x_double_fault_o     (dfault),
    .csr_mstatus_o        (mstatus),
    .csr_mie_o            (mie),
    .csr_mip_o            (mip),
    .csr_mepc_o           (mepc),
    .csr_mcause_o         (mcause)
  );

  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic st, input logic kl, input logic csr, input logic eret,
                               input logic [11:0] sel, input logic [31:0] wd, input logic [3:0] exc,
                               input logic tk, input logic [7:0] irqv, input logic [31:0] pcv);
    stall   = st;
    kill    = kl;
    is_csr  = csr;
    is_eret = eret;
    csr_sel = sel;
    wdata   = wd;
    exc_ill = exc[3];
    exc_bp  = exc[2];
    exc_ld  = exc[1];
    exc_st  = exc[0];
    tick    = tk;
    irq     = irqv;
    pc      = pcv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] irqv);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, irqv, 32'h0);
  endtask

  task automatic csrWrite(input logic [11:0] sel, input logic [31:0] wd, input logic [7:0] irqv);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, sel, wd, 4'b0000, 1'b0, irqv, 32'h0);
    nextCycle();
  endtask

  task automatic doMret(input logic [7:0] irqv);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'h0, 4'b0000, 1'b0, irqv, 32'h0);
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    idle(8'h00);
    nextCycle();
    nextCycle();
    checkOutput("rst_exc", {31'd0, exc_o}, 32'h0);
    checkOutput("rst_vec", vec_o, 32'h8);
    checkOutput("rst_mstatus", mstatus, 32'h0);
    checkOutput("rst_mie", mie, 32'h0);
    checkOutput("rst_mip", mip, 32'h0);
    checkOutput("rst_mepc", mepc, 32'h0);
    checkOutput("rst_mcause", mcause, 32'h0);
    checkOutput("rst_epc_o", epc_o, 32'h0);
    checkOutput("rst_dfault", {31'd0, dfault}, 32'h0);
    rst = 1'b0;

    $display("[TB] illegal instruction trap");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b1000, 1'b0, 8'h00, 32'h100);
    checkOutput("ill_exc", {31'd0, exc_o}, 32'h1);
    checkOutput("ill_vec", vec_o, 32'h8);
    nextCycle();
    idle(8'h00);
    checkOutput("ill_mepc", mepc, 32'h100);
    checkOutput("ill_epc_o", epc_o, 32'h100);
    checkOutput("ill_mcause", mcause, 32'h2);
    checkOutput("ill_mstatus", mstatus, 32'h0);

    $display("[TB] breakpoint inside trap");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0100, 1'b0, 8'h00, 32'h180);
    checkOutput("df_exc", {31'd0, exc_o}, 32'h0);
    nextCycle();
    idle(8'h00);
    checkOutput("df_flag", {31'd0, dfault}, 32'h1);
    checkOutput("df_mepc", mepc, 32'h100);
    checkOutput("df_mcause", mcause, 32'h2);
    doMret(8'h00);
    idle(8'h00);
    checkOutput("mret1_mstatus", mstatus, 32'h80);
    checkOutput("mret1_dfault", {31'd0, dfault}, 32'h1);
    checkOutput("mret1_exc", {31'd0, exc_o}, 32'h0);

    $display("[TB] CSR writes");
    csrWrite(MSTATUS, 32'h0000_0008, 8'h00);
    idle(8'h00);
    checkOutput("wr_mstatus", mstatus, 32'h08);
    csrWrite(MIE, 32'hFFFF_FFFF, 8'h00);
    idle(8'h00);
    checkOutput("wr_mie_mask", mie, 32'h00FF_0080);
    checkOutput("wr_mie_noexc", {31'd0, exc_o}, 32'h0);
    csrWrite(MIE, 32'h0004_0000, 8'h00);

    $display("[TB] edge interrupt on line 2");
    idle(8'h04);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h200);
    checkOutput("irq2_mip", mip, 32'h0004_0000);
    checkOutput("irq2_exc", {31'd0, exc_o}, 32'h1);
`ifdef URV_TRAP_VECTORED_EN
    checkOutput("irq2_vec", vec_o, 32'h50);
`else
    checkOutput("irq2_vec", vec_o, 32'h8);
`endif
    nextCycle();
    idle(8'h00);
    checkOutput("irq2_mcause", mcause, 32'h8000_0012);
    checkOutput("irq2_mepc", mepc, 32'h200);
    checkOutput("irq2_mstatus", mstatus, 32'h80);
    checkOutput("irq2_still_pending", mip, 32'h0004_0000);
    csrWrite(MIP, 32'h0, 8'h00);
    idle(8'h00);
    checkOutput("irq2_cleared", mip, 32'h0);
    doMret(8'h00);
    idle(8'h00);
    checkOutput("mret2_mstatus", mstatus, 32'h88);
    checkOutput("mret2_exc", {31'd0, exc_o}, 32'h0);

    $display("[TB] killed exception");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 4'b1000, 1'b0, 8'h00, 32'h280);
    checkOutput("kill_exc", {31'd0, exc_o}, 32'h0);
    nextCycle();
    idle(8'h00);
    checkOutput("kill_mepc", mepc, 32'h200);

    $display("[TB] lines 0 and 3 together");
    csrWrite(MIE, 32'h0009_0000, 8'h00);
    idle(8'h09);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h300);
    checkOutput("l03_mip", mip, 32'h0009_0000);
    checkOutput("l03_exc", {31'd0, exc_o}, 32'h1);
`ifdef URV_TRAP_VECTORED_EN
    checkOutput("l03_vec", vec_o, 32'h48);
`else
    checkOutput("l03_vec", vec_o, 32'h8);
`endif
    nextCycle();
    idle(8'h00);
    checkOutput("l03_mcause", mcause, 32'h8000_0010);
    checkOutput("l03_mepc", mepc, 32'h300);
    csrWrite(MIP, 32'h0008_0000, 8'h00);
    idle(8'h00);
    checkOutput("l03_clear0", mip, 32'h0008_0000);
    csrWrite(MIP, 32'h0, 8'h00);
    idle(8'h00);
    checkOutput("l03_clear3", mip, 32'h0);
    doMret(8'h00);
    idle(8'h00);
    checkOutput("mret3_mstatus", mstatus, 32'h88);

    $display("[TB] tick set beats simultaneous clear");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, MIP, 32'h0, 4'b0000, 1'b1, 8'h00, 32'h0);
    nextCycle();
    idle(8'h00);
    checkOutput("tick_setwins", mip, 32'h80);
    checkOutput("tick_disabled_exc", {31'd0, exc_o}, 32'h0);

    $display("[TB] stalled timer trap");
    csrWrite(MIE, 32'h0000_0080, 8'h00);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h400);
      checkOutput("stall_exc", {31'd0, exc_o}, 32'h1);
      nextCycle();
      checkOutput("stall_mepc", mepc, 32'h300);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, 8'h00, 32'h400);
    checkOutput("unstall_exc", {31'd0, exc_o}, 32'h1);
`ifdef URV_TRAP_VECTORED_EN
    checkOutput("tick_vec", vec_o, 32'h24);
`else
    checkOutput("tick_vec", vec_o, 32'h8);
`endif
    nextCycle();
    idle(8'h00);
    checkOutput("tick_mepc", mepc, 32'h400);
    checkOutput("tick_mcause", mcause, 32'h8000_0007);
    checkOutput("tick_mstatus", mstatus, 32'h80);

    $display("[TB] level line 4 retakes after mret");
    csrWrite(MIP, 32'h0, 8'h00);
    csrWrite(MIE, 32'h0010_0000, 8'h10);
    idle(8'h10);
    checkOutput("lvl_mip", mip, 32'h0010_0000);
    checkOutput("lvl_trap_exc", {31'd0, exc_o}, 32'h0);
    doMret(8'h10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'b0000, 1'b0, 8'h10, 32'h500);
    checkOutput("lvl_mstatus", mstatus, 32'h88);
    checkOutput("lvl_exc", {31'd0, exc_o}, 32'h1);
    nextCycle();
    idle(8'h00);
    checkOutput("lvl_mcause", mcause, 32'h8000_0014);
    checkOutput("lvl_mepc", mepc, 32'h500);
    checkOutput("lvl_mstatus_trap", mstatus, 32'h80);
    nextCycle();
    checkOutput("lvl_mip_drop", mip, 32'h0);
    checkOutput("final_dfault", {31'd0, dfault}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
